// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase req/ack handshake crossing (transmit and receive sides).
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_ACK  = 2'd2
  } hs_state_t;

  localparam int HS_SYNC_N = 2;

endpackage

// File: rtl/hs_sync.sv
// Level synchroniser: SYNC_N flops bringing an asynchronous level into clkin, async reset to 0.
module hs_sync
  import hs_pkg::*;
#(
  parameter int SYNC_N = HS_SYNC_N
) (
  input  logic clkin,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_N-1:0] chain;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) chain <= '0;
    else       chain <= {chain[SYNC_N-2:0], d};
  end

  assign q = chain[SYNC_N-1];

endmodule

// File: rtl/hs_data_tx.sv
// Source-side initiator of the 4-phase req/ack crossing with a 1-entry pending buffer.
// Optional REQ timeout is compiled in with `define HS_TX_TIMEOUT_EN.
module hs_data_tx
  import hs_pkg::*;
#(
  parameter int DW      = 8,
  parameter int SYNC_N  = HS_SYNC_N,
  parameter int TMO_CYC = 255
) (
  input  logic          clkin,
  input  logic          rstn,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  output logic          din_rdy,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          done_o,
  output logic          busy_o,
  output logic          ovf_o,
  input  logic          ovf_clr,
  output logic          tmo_o
);

  hs_state_t     state, state_nxt;
  logic          ack_s;
  logic          req_nxt;
  logic          pend_vld;
  logic [DW-1:0] pend_data;
  logic          launch_din, launch_pend;
  logic          capture, drop;
  logic          tmo_expire;
  logic          abort_q;

  hs_sync #(.SYNC_N(SYNC_N)) u_ack_sync (
    .clkin (clkin),
    .rstn  (rstn),
    .d     (ack_i),
    .q     (ack_s)
  );

  // The pending word is older than anything on din, so it always launches first.
  always_comb begin
    state_nxt   = state;
    req_nxt     = req_o;
    launch_din  = 1'b0;
    launch_pend = 1'b0;
    done_o      = 1'b0;
    case (state)
      HS_IDLE: begin
        if (pend_vld) begin
          launch_pend = 1'b1;
          req_nxt     = 1'b1;
          state_nxt   = HS_REQ;
        end else if (din_vld) begin
          launch_din = 1'b1;
          req_nxt    = 1'b1;
          state_nxt  = HS_REQ;
        end
      end
      HS_REQ: begin
        if (ack_s || tmo_expire) begin
          req_nxt   = 1'b0;
          state_nxt = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!ack_s) begin
          done_o = !abort_q;
          if (pend_vld) begin
            launch_pend = 1'b1;
            req_nxt     = 1'b1;
            state_nxt   = HS_REQ;
          end else begin
            state_nxt = HS_IDLE;
          end
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = HS_IDLE;
      end
    endcase
  end

  assign capture = din_vld && !launch_din && (!pend_vld || launch_pend);
  assign drop    = din_vld && !launch_din && pend_vld && !launch_pend;
  assign din_rdy = !pend_vld;
  assign busy_o  = (state != HS_IDLE);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state     <= HS_IDLE;
      req_o     <= 1'b0;
      data_o    <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      ovf_o     <= 1'b0;
    end else begin
      state <= state_nxt;
      req_o <= req_nxt;
      if (launch_din)       data_o <= din;
      else if (launch_pend) data_o <= pend_data;
      if (capture) begin
        pend_vld  <= 1'b1;
        pend_data <= din;
      end else if (launch_pend) begin
        pend_vld <= 1'b0;
      end
      if (drop)         ovf_o <= 1'b1;
      else if (ovf_clr) ovf_o <= 1'b0;
    end
  end

`ifdef HS_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Ack arriving on the expiry cycle still completes the word normally.
  assign tmo_expire = (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign tmo_hit    = (state == HS_REQ) && !ack_s && tmo_expire;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      abort_q <= 1'b0;
      tmo_o   <= 1'b0;
    end else begin
      if (state == HS_REQ && state_nxt == HS_REQ) tmo_cnt <= tmo_cnt + 1'b1;
      else                                        tmo_cnt <= '0;
      if (tmo_hit)                         abort_q <= 1'b1;
      else if (state == HS_ACK && !ack_s)  abort_q <= 1'b0;
      if (tmo_hit)      tmo_o <= 1'b1;
      else if (ovf_clr) tmo_o <= 1'b0;
    end
  end
`else
  assign tmo_expire = 1'b0;
  assign abort_q    = 1'b0;
  assign tmo_o      = 1'b0;
`endif

endmodule

// File: tb/tb_hs_data_tx.sv
// Directed bench for hs_data_tx with a behavioural remote receiver answering req_o on ack_i.
module tb_hs_data_tx;

  localparam int DW      = 8;
  localparam int SYNC_N  = 2;
  localparam int TMO_CYC = 16;

  logic          clkin = 1'b0;
  logic          rstn = 1'b0;
  logic          din_vld = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_rdy;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i = 1'b0;
  logic          done_o;
  logic          busy_o;
  logic          ovf_o;
  logic          ovf_clr = 1'b0;
  logic          tmo_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit resp_en = 1'b0;
  bit rand_dly = 1'b0;
  int ack_dly = 5;
  int rel_dly = 2;
  int ack_rise_cyc = 0;
  int req_fall_cyc = 0;
  int data_viol = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] done_q[$];

  hs_data_tx #(.DW(DW), .SYNC_N(SYNC_N), .TMO_CYC(TMO_CYC)) dut (
    .clkin   (clkin),
    .rstn    (rstn),
    .din_vld (din_vld),
    .din     (din),
    .din_rdy (din_rdy),
    .req_o   (req_o),
    .data_o  (data_o),
    .ack_i   (ack_i),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o),
    .ovf_clr (ovf_clr),
    .tmo_o   (tmo_o)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Completed words are logged as data_o in the done_o cycle; data_o must not move under req_o.
  always @(negedge clkin) begin
    if (rstn && done_o) done_q.push_back(data_o);
    if (prev_req && req_o && data_o !== prev_data) data_viol++;
    if (prev_req && !req_o) req_fall_cyc = cyc;
    prev_req  = req_o;
    prev_data = data_o;
  end

  // Remote receiver: raise ack after a delay, drop it some cycles after req_o falls.
  initial begin
    forever begin
      @(negedge clkin);
      if (resp_en && rstn && req_o && !ack_i) begin
        int d;
        d = rand_dly ? int'($urandom_range(20, 0)) : ack_dly;
        for (int i = 0; i < d && req_o; i++) @(negedge clkin);
        if (req_o) begin
          ack_i = 1'b1;
          ack_rise_cyc = cyc;
        end
        for (int i = 0; i < 500 && req_o; i++) @(negedge clkin);
        d = rand_dly ? int'($urandom_range(3, 0)) : rel_dly;
        repeat (d) @(negedge clkin);
        ack_i = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clkin);
    end
    if (done_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    checks++;
    if (req_o !== 1'b0 || data_o !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_req_data: req_o=%b data_o=%h, required 0/00", req_o, data_o);
    end
    checks++;
    if (din_rdy !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: din_rdy=%b busy_o=%b done_o=%b, required 1/0/0", din_rdy, busy_o, done_o);
    end
    checks++;
    if (ovf_o !== 1'b0 || tmo_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_sticky: ovf_o=%b tmo_o=%b, required 0/0", ovf_o, tmo_o);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    bit ok;
    int dly;
    resp_en = 1'b1; rand_dly = 1'b0; ack_dly = 5; rel_dly = 2;
    done_q.delete();
    tick();
    din = 8'hA5; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    checks++;
    if (req_o !== 1'b1 || data_o !== 8'hA5 || busy_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_launch: req_o=%b data_o=%h busy_o=%b, required 1/a5/1", req_o, data_o, busy_o);
    end
    wait_done(1, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL single_done_timeout: done count=%0d, required 1", done_q.size());
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL single_value: count=%0d first=%h, required 1/a5", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : 8'hxx);
    end
    dly = req_fall_cyc - ack_rise_cyc;
    checks++;
    if (dly < SYNC_N || dly > SYNC_N + 1) begin
      failures++;
      $display("[TB] FAIL single_req_fall: req_o fell %0d cycles after ack_i, required %0d..%0d", dly, SYNC_N, SYNC_N + 1);
    end
    tick();
    tick();
    checks++;
    if (busy_o !== 1'b0 || req_o !== 1'b0 || done_q.size() != 1) begin
      failures++;
      $display("[TB] FAIL single_idle: busy_o=%b req_o=%b dones=%0d, required 0/0/1", busy_o, req_o, done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ack_dly = 4; rel_dly = 1;
    done_q.delete();
    tick();
    din = 8'h11; din_vld = 1'b1;
    tick();
    din = 8'h22;
    tick();
    din_vld = 1'b0;
    checks++;
    if (din_rdy !== 1'b0 || data_o !== 8'h11) begin
      failures++;
      $display("[TB] FAIL b2b_pending: din_rdy=%b data_o=%h, required 0/11", din_rdy, data_o);
    end
    wait_done(2, 200, ok);
    checks++;
    if (!ok || done_q.size() != 2) begin
      failures++;
      $display("[TB] FAIL b2b_count: dones=%0d, required 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] !== 8'h11 || done_q[1] !== 8'h22) begin
        failures++;
        $display("[TB] FAIL b2b_order: got %h,%h, required 11,22", done_q[0], done_q[1]);
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    bit ok;
    ack_dly = 30; rel_dly = 1;
    done_q.delete();
    tick();
    din_vld = 1'b1;
    din = 8'h01; tick();
    din = 8'h02; tick();
    din = 8'h03; tick();
    din_vld = 1'b0;
    checks++;
    if (ovf_o !== 1'b1 || din_rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_set: ovf_o=%b din_rdy=%b, required 1/0", ovf_o, din_rdy);
    end
    ovf_clr = 1'b1; din = 8'h04; din_vld = 1'b1;
    tick();
    ovf_clr = 1'b0; din_vld = 1'b0;
    checks++;
    if (ovf_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_set_wins: ovf_o=%b, required 1", ovf_o);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear: ovf_o=%b, required 0", ovf_o);
    end
    wait_done(2, 300, ok);
    repeat (40) @(negedge clkin);
    checks++;
    if (!ok || done_q.size() != 2) begin
      failures++;
      $display("[TB] FAIL ovf_count: dones=%0d, required 2", done_q.size());
    end else begin
      checks++;
      if (done_q[0] !== 8'h01 || done_q[1] !== 8'h02) begin
        failures++;
        $display("[TB] FAIL ovf_order: got %h,%h, required 01,02", done_q[0], done_q[1]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    ack_dly = 30; rel_dly = 1;
    done_q.delete();
    tick();
    din = 8'h5A; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    repeat (3) tick();
    checks++;
    if (req_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre: req_o=%b, required 1", req_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (req_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0 || din_rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_async: req_o=%b data_o=%h busy_o=%b din_rdy=%b, required 0/00/0/1",
               req_o, data_o, busy_o, din_rdy);
    end
    repeat (3) tick();
    rstn = 1'b1;
    repeat (5) tick();
    done_q.delete();
    ack_dly = 3;
    din = 8'h66; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    wait_done(1, 100, ok);
    checks++;
    if (!ok || done_q.size() != 1 || done_q[0] !== 8'h66) begin
      failures++;
      $display("[TB] FAIL midrst_recover: dones=%0d first=%h, required 1/66", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : 8'hxx);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int hi;
    resp_en = 1'b0;
    done_q.delete();
    tick();
    din = 8'h77; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin);
      if (req_o) hi++;
    end
`ifdef HS_TX_TIMEOUT_EN
    checks++;
    if (hi != TMO_CYC || tmo_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tmo_abort: req_o high %0d cycles tmo_o=%b, required %0d/1", hi, tmo_o, TMO_CYC);
    end
    checks++;
    if (done_q.size() != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_no_done: dones=%0d busy_o=%b, required 0/0", done_q.size(), busy_o);
    end
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (tmo_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_clear: tmo_o=%b, required 0", tmo_o);
    end
    resp_en = 1'b1;
    ok = 1'b1;
`else
    checks++;
    if (hi != 40 || req_o !== 1'b1 || tmo_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tmo_hold: req_o high %0d cycles req_o=%b tmo_o=%b, required 40/1/0", hi, req_o, tmo_o);
    end
    ack_dly = 2; rel_dly = 1;
    resp_en = 1'b1;
    wait_done(1, 100, ok);
    checks++;
    if (!ok || done_q[0] !== 8'h77) begin
      failures++;
      $display("[TB] FAIL tmo_release: dones=%0d, required word 77 delivered", done_q.size());
    end
`endif
    tick();
  endtask

  task automatic test_random();
    bit ok;
    int sent;
    int bad;
    logic [DW-1:0] exp_q[$];
    rand_dly = 1'b1; resp_en = 1'b1;
    done_q.delete();
    data_viol = 0;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 1000; c++) begin
      tick();
      din_vld = 1'b0;
      if ($urandom_range(3, 0) != 0 && din_rdy) begin
        din = DW'($urandom);
        din_vld = 1'b1;
        exp_q.push_back(din);
        sent++;
      end
    end
    tick();
    din_vld = 1'b0;
    wait_done(exp_q.size(), 2000, ok);
    checks++;
    if (sent != 1000 || !ok || done_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL rand_count: sent=%0d delivered=%0d, required 1000/1000", sent, done_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < done_q.size(); i++) begin
      checks++;
      if (done_q[i] !== exp_q[i]) begin
        failures++;
        bad++;
        if (bad <= 5) $display("[TB] FAIL rand_word[%0d]: got %h, required %h", i, done_q[i], exp_q[i]);
      end
    end
    checks++;
    if (data_viol != 0) begin
      failures++;
      $display("[TB] FAIL rand_data_stable: data_o changed %0d times under req_o, required 0", data_viol);
    end
    rand_dly = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
